// File: rtl/ctrl_hazard.sv
// rtl/ctrl_hazard.sv - ID/EX/MEM/WB hazard, freeze and flush sequencing controller
// Optional: `define CTRL_HAZARD_FWD_EN for load-use-only stalls plus EX operand forwarding.
module ctrl_hazard #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          WB_BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_id_valid,
  input  logic [15:0] i_id_ir,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic        i_id_rd_we,
  input  logic        i_id_mem_rd,
  input  logic        i_id_mem_wr,
  input  logic        i_ex_branch_taken,
  input  logic        i_mem_ack,
  output logic        o_stall_if_id,
  output logic        o_bubble_ex,
  output logic        o_freeze,
  output logic        o_flush,
  output logic        o_mem_err,
  output logic [15:0] o_busy_regs,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b
);

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       we;
    logic       ld;
    logic       mem;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } slot_t;

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_MEM_ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  slot_t      ex_s, mem_s, wb_s, id_s;
  logic [3:0] rs1, rs2;
  logic       hit1, hit2, hz, wait_req, freeze, flush;
  logic       unused_bits;

  function automatic logic pend(input slot_t s, input logic [3:0] r);
    return s.v && s.we && (s.rd == r) && (r != 4'd0);
  endfunction

  assign rs1         = i_id_ir[7:4];
  assign rs2         = i_id_ir[3:0];
  assign unused_bits = ^{i_id_ir[15:12], wb_s.ld, wb_s.mem, wb_s.rs1, wb_s.rs2};

  always_comb begin
    id_s     = '0;
    id_s.v   = 1'b1;
    id_s.rd  = i_id_ir[11:8];
    id_s.we  = i_id_rd_we;
    id_s.ld  = i_id_mem_rd;
    id_s.mem = i_id_mem_rd | i_id_mem_wr;
    id_s.rs1 = rs1;
    id_s.rs2 = rs2;
  end

`ifdef CTRL_HAZARD_FWD_EN
  // Everything except a load result can be forwarded, so only load-use stalls.
  function automatic logic load_use(input slot_t s, input logic [3:0] r);
    return s.v && s.ld && (s.rd == r) && (r != 4'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m, input slot_t w,
                                         input logic [3:0] r);
    if (!e.v || r == 4'd0) return 2'b00;
    if (m.v && m.we && !m.ld && m.rd == r) return 2'b01;
    if (w.v && w.we && w.rd == r) return 2'b10;
    return 2'b00;
  endfunction

  assign hit1    = load_use(ex_s, rs1);
  assign hit2    = load_use(ex_s, rs2);
  assign o_fwd_a = fwd_sel(ex_s, mem_s, wb_s, ex_s.rs1);
  assign o_fwd_b = fwd_sel(ex_s, mem_s, wb_s, ex_s.rs2);
`else
  assign hit1    = pend(ex_s, rs1) || pend(mem_s, rs1) || (!WB_BYPASS && pend(wb_s, rs1));
  assign hit2    = pend(ex_s, rs2) || pend(mem_s, rs2) || (!WB_BYPASS && pend(wb_s, rs2));
  assign o_fwd_a = 2'b00;
  assign o_fwd_b = 2'b00;
`endif

  assign hz       = i_id_valid && ((i_id_rs1_used && hit1) || (i_id_rs2_used && hit2));
  assign wait_req = mem_s.v && mem_s.mem && !i_mem_ack;
  assign cnt_inc  = cnt + 8'd1;

  always_comb begin
    freeze = 1'b0;
    case (state)
      S_RUN:      freeze = wait_req;
      S_MEM_WAIT: freeze = !i_mem_ack;
      default:    freeze = 1'b0;
    endcase
  end

  assign flush         = i_ex_branch_taken && ex_s.v && !freeze;
  assign o_freeze      = freeze;
  assign o_flush       = flush;
  assign o_stall_if_id = freeze || (!flush && hz);
  assign o_bubble_ex   = !freeze && !flush && hz;
  assign o_mem_err     = (state == S_MEM_ERR);

  always_comb begin
    o_busy_regs = '0;
    for (int r = 1; r < 16; r++)
      o_busy_regs[r] = pend(ex_s, 4'(r)) || pend(mem_s, 4'(r)) || pend(wb_s, 4'(r));
  end

  // cnt counts freeze cycles already spent on the current access, the first one included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (wait_req) begin
            cnt   <= 8'd1;
            state <= (TIMEOUT <= 8'd1) ? S_MEM_ERR : S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (i_mem_ack) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= TIMEOUT) state <= S_MEM_ERR;
          end
        end
        S_MEM_ERR: begin
          state <= S_RUN;
          cnt   <= '0;
        end
        default: begin
          state <= S_RUN;
          cnt   <= '0;
        end
      endcase

      if (!freeze) begin
        wb_s <= mem_s;
        if (state == S_MEM_ERR) wb_s.we <= 1'b0;
        mem_s <= ex_s;
        ex_s  <= (i_id_valid && !hz && !flush) ? id_s : '0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_hazard.sv
// tb/tb_ctrl_hazard.sv - directed table and sequence checks for ctrl_hazard
module tb_ctrl_hazard;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, rs1_used, rs2_used, rd_we, mem_rd, mem_wr, br, ack;
  logic [15:0] id_ir;
  logic        stall, bubble, freeze, flush, mem_err;
  logic [15:0] busy;
  logic [1:0]  fwd_a, fwd_b;

  int checks = 0;
  int errors = 0;

  ctrl_hazard #(.MEM_TIMEOUT(4), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_ir(id_ir),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_id_rd_we(rd_we),
    .i_id_mem_rd(mem_rd), .i_id_mem_wr(mem_wr),
    .i_ex_branch_taken(br), .i_mem_ack(ack),
    .o_stall_if_id(stall), .o_bubble_ex(bubble), .o_freeze(freeze), .o_flush(flush),
    .o_mem_err(mem_err), .o_busy_regs(busy), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  // ctl = {valid, rs1_used, rs2_used, rd_we, mem_rd, mem_wr, branch_taken, mem_ack}
  // exp = {stall_if_id, bubble_ex, freeze, flush, mem_err}
  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] ir;
    logic [4:0]  exp;
    logic [15:0] busy;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [7:0] ctl, input logic [15:0] ir,
                     input logic [4:0] exp, input logic [15:0] bsy);
    vec_t t;
    t.ctl = ctl; t.ir = ir; t.exp = exp; t.busy = bsy;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [15:0] ir);
    {id_valid, rs1_used, rs2_used, rd_we, mem_rd, mem_wr, br, ack} = ctl;
    id_ir = ir;
  endtask

  task automatic step(input logic [7:0] ctl, input logic [15:0] ir);
    @(posedge clk);
    #1;
    drive(ctl, ir);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(8'h00, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'($urandom), 16'($urandom));
    @(posedge clk);
    #1;
    drive(8'($urandom), 16'($urandom));
    @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {stall, bubble, freeze, flush, mem_err}, 5'b00000);
    chk("reset_busy", busy, 16'h0000);
    chk("reset_fwd", {fwd_a, fwd_b}, 4'b0000);

`ifndef CTRL_HAZARD_FWD_EN
    // RAW on r3: two stall cycles, third cycle reads r3 through the write-before-read file.
    row(8'b1111_0000, 16'h1312, 5'b00000, 16'h0000);
    row(8'b1100_0000, 16'h2430, 5'b11000, 16'h0008);
    row(8'b1100_0000, 16'h2430, 5'b11000, 16'h0008);
    row(8'b1100_0000, 16'h2430, 5'b00000, 16'h0008);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0000);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0000);
    // Taken branch in EX while ID has a hazard: flush wins, EX gets a bubble.
    row(8'b1001_0000, 16'h1700, 5'b00000, 16'h0000);
    row(8'b1101_0010, 16'h2070, 5'b00010, 16'h0080);
    row(8'b0000_0010, 16'h0000, 5'b00000, 16'h0080);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0080);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0000);
    // Store waits three cycles for ack, then everything advances on the ack cycle.
    row(8'b1110_0100, 16'h0012, 5'b00000, 16'h0000);
    row(8'b1001_0000, 16'h1900, 5'b00000, 16'h0000);
    row(8'b1001_0000, 16'h1a00, 5'b10100, 16'h0200);
    row(8'b1001_0000, 16'h1a00, 5'b10100, 16'h0200);
    row(8'b1001_0000, 16'h1a00, 5'b10100, 16'h0200);
    row(8'b1001_0001, 16'h1a00, 5'b00000, 16'h0200);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0600);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0600);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0400);
    row(8'b0000_0000, 16'h0000, 5'b00000, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(tbl[i].ctl, tbl[i].ir);
      @(negedge clk);
      chk($sformatf("row%0d_stall", i),  stall,   tbl[i].exp[4]);
      chk($sformatf("row%0d_bubble", i), bubble,  tbl[i].exp[3]);
      chk($sformatf("row%0d_freeze", i), freeze,  tbl[i].exp[2]);
      chk($sformatf("row%0d_flush", i),  flush,   tbl[i].exp[1]);
      chk($sformatf("row%0d_err", i),    mem_err, tbl[i].exp[0]);
      chk($sformatf("row%0d_busy", i),   busy,    tbl[i].busy);
    end
`else
    // Forwarding build: ALU RAW forwards from MEM with no stall.
    reset_dut();
    step(8'b1111_0000, 16'h1312);
    chk("fwd_raw_stall0", stall, 1'b0);
    step(8'b1100_0000, 16'h2430);
    chk("fwd_raw_stall1", stall, 1'b0);
    step(8'b0000_0000, 16'h0000);
    chk("fwd_raw_a", fwd_a, 2'b01);
    chk("fwd_raw_b", fwd_b, 2'b00);
    // Load-use on r5: one bubble, then the operand comes from WB.
    reset_dut();
    step(8'b1001_1001, 16'h1500);
    chk("lu_load_stall", stall, 1'b0);
    step(8'b1100_0001, 16'h2050);
    chk("lu_stall", stall, 1'b1);
    chk("lu_bubble", bubble, 1'b1);
    step(8'b1100_0001, 16'h2050);
    chk("lu_release", stall, 1'b0);
    step(8'b0000_0001, 16'h0000);
    chk("lu_fwd_a", fwd_a, 2'b10);
`endif

    // Load to r6 never acked: four freeze cycles, error pulse, r6 not written back.
    reset_dut();
    step(8'b1001_1000, 16'h1600);
    step(8'b0000_0000, 16'h0000);
    chk("to_pre_freeze", freeze, 1'b0);
    chk("to_pre_busy", busy, 16'h0040);
    for (int k = 0; k < 4; k++) begin
      step(8'b0000_0000, 16'h0000);
      chk($sformatf("to_freeze%0d", k), freeze, 1'b1);
      chk($sformatf("to_noerr%0d", k), mem_err, 1'b0);
    end
    step(8'b0000_0000, 16'h0000);
    chk("to_err", mem_err, 1'b1);
    chk("to_err_freeze", freeze, 1'b0);
    chk("to_err_busy", busy, 16'h0040);
    step(8'b0000_0000, 16'h0000);
    chk("to_err_pulse", mem_err, 1'b0);
    chk("to_wb_busy", busy, 16'h0000);

    // Ack arriving on the last allowed cycle wins over the timeout.
    reset_dut();
    step(8'b1001_1000, 16'h1600);
    step(8'b0000_0000, 16'h0000);
    for (int k = 0; k < 3; k++) step(8'b0000_0000, 16'h0000);
    chk("edge_freeze3", freeze, 1'b1);
    step(8'b0000_0001, 16'h0000);
    chk("edge_ack_freeze", freeze, 1'b0);
    chk("edge_ack_err", mem_err, 1'b0);
    step(8'b0000_0000, 16'h0000);
    chk("edge_after_err", mem_err, 1'b0);
    chk("edge_wb_busy", busy, 16'h0040);

    // Reset while waiting on memory returns straight to RUN with empty slots.
    reset_dut();
    step(8'b1001_1000, 16'h1600);
    step(8'b0000_0000, 16'h0000);
    step(8'b0000_0000, 16'h0000);
    step(8'b0000_0000, 16'h0000);
    chk("rw_freeze_before", freeze, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_freeze", freeze, 1'b0);
    chk("rw_busy", busy, 16'h0000);
    chk("rw_err", mem_err, 1'b0);
    step(8'b0000_0000, 16'h0000);
    chk("rw_freeze_next", freeze, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
